// File: rtl/butterfly_control.sv
// Step-button sequencer for the butterfly datapath: debounces the step button and walks the
// operand-entry / result-display sequence, driving the eight datapath strobes (Moore outputs).
module butterfly_control #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_in,
    output logic       load_coeff,
    output logic       load_b,
    output logic       load_mult,
    output logic       multiply,
    output logic       load_output_reg,
    output logic       subtract,
    output logic       mult_out_select,
    output logic       fbr_input,
    output logic [3:0] phase,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [4:0] {
        StWaitRw, StWaitIw, StWaitRb, StWaitIb, StWaitRa, StWaitIa,
        StDispIy, StDispRz, StDispIz,
        StPulseRw, StPulseIw, StPulseRb, StPulseIb,
        StM0, StM1, StM2, StM3,
        StN0, StN1,
        StQ0, StQ1
    } state_e;

    state_e          state_q, state_d;
    logic            sync_meta, sync, stable, stable_prev, step_pulse;
    logic [CntW-1:0] cnt;
    logic [7:0]      strb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta   <= 1'b0;
            sync        <= 1'b0;
            stable      <= 1'b0;
            stable_prev <= 1'b0;
            cnt         <= '0;
            step_pulse  <= 1'b0;
        end else begin
            sync_meta   <= step_in;
            sync        <= sync_meta;
            stable_prev <= stable;
            // Only press edges step the sequence; releases are ignored.
            step_pulse  <= stable & ~stable_prev;
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CntLast) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StWaitRw;
        end else begin
            state_q <= state_d;
        end
    end

    // Transient states advance unconditionally, so a pulse during a burst is dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitRw:  if (step_pulse) state_d = StPulseRw;
            StWaitIw:  if (step_pulse) state_d = StPulseIw;
            StWaitRb:  if (step_pulse) state_d = StPulseRb;
            StWaitIb:  if (step_pulse) state_d = StPulseIb;
            StWaitRa:  if (step_pulse) state_d = StM0;
            StWaitIa:  if (step_pulse) state_d = StN0;
            StDispIy:  if (step_pulse) state_d = StQ0;
            StDispRz:  if (step_pulse) state_d = StQ1;
            StDispIz:  if (step_pulse) state_d = StWaitRw;
            StPulseRw: state_d = StWaitIw;
            StPulseIw: state_d = StWaitRb;
            StPulseRb: state_d = StWaitIb;
            StPulseIb: state_d = StWaitRa;
            StM0:      state_d = StM1;
            StM1:      state_d = StM2;
            StM2:      state_d = StM3;
            StM3:      state_d = StWaitIa;
            StN0:      state_d = StN1;
            StN1:      state_d = StDispIy;
            StQ0:      state_d = StDispRz;
            StQ1:      state_d = StDispIz;
            default:   state_d = StWaitRw;
        endcase
    end

    // strb bits: load_coeff, load_b, load_mult, multiply, load_output_reg, subtract,
    // mult_out_select, fbr_input (MSB first).
    always_comb begin
        strb  = 8'h00;
        phase = 4'd0;
        busy  = 1'b0;
        unique case (state_q)
            StWaitRw:  phase = 4'd0;
            StWaitIw:  phase = 4'd1;
            StWaitRb:  phase = 4'd2;
            StWaitIb:  phase = 4'd3;
            StWaitRa:  phase = 4'd4;
            StWaitIa:  phase = 4'd5;
            StDispIy:  phase = 4'd6;
            StDispRz:  phase = 4'd7;
            StDispIz:  phase = 4'd8;
            StPulseRw: begin phase = 4'd0; busy = 1'b1; strb = 8'h80; end
            StPulseIw: begin phase = 4'd1; busy = 1'b1; strb = 8'h80; end
            StPulseRb: begin phase = 4'd2; busy = 1'b1; strb = 8'h40; end
            StPulseIb: begin phase = 4'd3; busy = 1'b1; strb = 8'h40; end
            StM0:      begin phase = 4'd4; busy = 1'b1; strb = 8'h64; end
            StM1:      begin phase = 4'd4; busy = 1'b1; strb = 8'h70; end
            StM2:      begin phase = 4'd4; busy = 1'b1; strb = 8'h19; end
            StM3:      begin phase = 4'd4; busy = 1'b1; strb = 8'h08; end
            StN0:      begin phase = 4'd5; busy = 1'b1; strb = 8'h0B; end
            StN1:      begin phase = 4'd5; busy = 1'b1; strb = 8'h0A; end
            StQ0:      begin phase = 4'd6; busy = 1'b1; strb = 8'h0C; end
            StQ1:      begin phase = 4'd7; busy = 1'b1; strb = 8'h0E; end
            default:   begin phase = 4'd0; busy = 1'b0; strb = 8'h00; end
        endcase
    end

    assign {load_coeff, load_b, load_mult, multiply, load_output_reg, subtract,
            mult_out_select, fbr_input} = strb;

endmodule

// File: tb/tb_butterfly_control.sv
// Scoreboard bench for butterfly_control: one instance with D=4 (latency, bounce) and one
// with D=1 (full walk, dropped pulse, reset mid-burst).
module tb_butterfly_control;

    typedef struct packed {
        logic [7:0] s;
        logic [3:0] ph;
    } exp_t;

    logic clk;
    logic rst4, step4, rst1, step1;
    logic lc4, lb4, lm4, mul4, lor4, sub4, mos4, fbr4, busy4;
    logic lc1, lb1, lm1, mul1, lor1, sub1, mos1, fbr1, busy1;
    logic [3:0] phase4, phase1;
    logic [7:0] s4, s1;

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;
    int   n_vec = 0;
    int   n_err = 0;
    logic cnt_en = 1'b0;
    int   cnt_lc = 0, cnt_lb = 0, cnt_lor = 0;

    assign s4 = {lc4, lb4, lm4, mul4, lor4, sub4, mos4, fbr4};
    assign s1 = {lc1, lb1, lm1, mul1, lor1, sub1, mos1, fbr1};

    butterfly_control #(.DEBOUNCE_CYCLES(4)) u4 (
        .clk(clk), .reset(rst4), .step_in(step4),
        .load_coeff(lc4), .load_b(lb4), .load_mult(lm4), .multiply(mul4),
        .load_output_reg(lor4), .subtract(sub4), .mult_out_select(mos4), .fbr_input(fbr4),
        .phase(phase4), .busy(busy4)
    );

    butterfly_control #(.DEBOUNCE_CYCLES(1)) u1 (
        .clk(clk), .reset(rst1), .step_in(step1),
        .load_coeff(lc1), .load_b(lb1), .load_mult(lm1), .multiply(mul1),
        .load_output_reg(lor1), .subtract(sub1), .mult_out_select(mos1), .fbr_input(fbr1),
        .phase(phase1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] s, input logic [3:0] ph);
        exp_t e;
        e.s  = s;
        e.ph = ph;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Expected transient-state strobes for a step taken from wait phase p (D=1 instance).
    task automatic push1(input int p);
        case (p)
            0: q1.push_back(mk(8'h80, 4'd0));
            1: q1.push_back(mk(8'h80, 4'd1));
            2: q1.push_back(mk(8'h40, 4'd2));
            3: q1.push_back(mk(8'h40, 4'd3));
            4: begin
                q1.push_back(mk(8'h64, 4'd4));
                q1.push_back(mk(8'h70, 4'd4));
                q1.push_back(mk(8'h19, 4'd4));
                q1.push_back(mk(8'h08, 4'd4));
            end
            5: begin
                q1.push_back(mk(8'h0B, 4'd5));
                q1.push_back(mk(8'h0A, 4'd5));
            end
            6: q1.push_back(mk(8'h0C, 4'd6));
            7: q1.push_back(mk(8'h0E, 4'd7));
            default: ;
        endcase
    endtask

    task automatic press1();
        step1 = 1'b1;
        repeat (6) @(negedge clk);
        step1 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Monitor: every busy cycle is a presented output and must match the next queued entry.
    always @(negedge clk) begin
        if (busy4) begin
            n_vec++;
            if (q4.size() == 0) begin
                n_err++;
                $display("FAIL u4 burst: got strobes=%b phase=%0d, required no burst", s4, phase4);
            end else begin
                e4 = q4.pop_front();
                if (s4 !== e4.s || phase4 !== e4.ph) begin
                    n_err++;
                    $display("FAIL u4 burst: got strobes=%b phase=%0d, required strobes=%b phase=%0d",
                             s4, phase4, e4.s, e4.ph);
                end
            end
        end
        if (busy1) begin
            n_vec++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL u1 burst: got strobes=%b phase=%0d, required no burst", s1, phase1);
            end else begin
                e1 = q1.pop_front();
                if (s1 !== e1.s || phase1 !== e1.ph) begin
                    n_err++;
                    $display("FAIL u1 burst: got strobes=%b phase=%0d, required strobes=%b phase=%0d",
                             s1, phase1, e1.s, e1.ph);
                end
            end
        end
        if (cnt_en) begin
            cnt_lc  += int'(lc1);
            cnt_lb  += int'(lb1);
            cnt_lor += int'(lor1);
        end
    end

    initial begin
        int   first;
        int   nbusy;
        logic early;

        rst4 = 1'b0; step4 = 1'b1;
        rst1 = 1'b0; step1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset strobes", 32'(s4), 32'h0);
        check("reset phase", 32'(phase4), 32'h0);
        check("reset busy", 32'(busy4), 32'h0);

        // First step latency with the button already held through reset.
        q4.push_back(mk(8'h80, 4'd0));
        rst4  = 1'b1;
        early = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i < 7 && (s4 != 8'h00 || busy4)) early = 1'b1;
            if (i == 7) begin
                check("latency load_coeff", 32'(lc4), 32'h1);
                check("latency busy", 32'(busy4), 32'h1);
            end
            if (i == 8) begin
                check("phase after step", 32'(phase4), 32'h1);
                check("busy after step", 32'(busy4), 32'h0);
            end
        end
        check("no early strobe", 32'(early), 32'h0);

        // Bounce rejection: short pulses ignored, one step timed from the final rise.
        step4 = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            step4 = 1'b1;
            repeat (2) @(negedge clk);
            step4 = 1'b0;
            repeat (2) @(negedge clk);
        end
        q4.push_back(mk(8'h80, 4'd1));
        step4 = 1'b1;
        first = -1;
        nbusy = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy4) begin
                nbusy++;
                if (first < 0) first = i;
            end
        end
        check("bounce step count", 32'(nbusy), 32'd1);
        check("bounce step edge", 32'(first), 32'd7);
        check("bounce phase", 32'(phase4), 32'd2);
        step4 = 1'b0;

        // Full walk with D=1.
        rst1 = 1'b1;
        repeat (2) @(negedge clk);
        check("walk start phase", 32'(phase1), 32'd0);
        cnt_en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            push1(k);
            press1();
            check("walk phase", 32'(phase1), 32'((k + 1) % 9));
        end
        cnt_en = 1'b0;
        check("load_coeff total", 32'(cnt_lc), 32'd2);
        check("load_b total", 32'(cnt_lb), 32'd4);
        check("load_output_reg total", 32'(cnt_lor), 32'd6);

        // Busy drop: a second press edge lands its pulse during M1.
        for (int k = 0; k < 4; k++) begin
            push1(k);
            press1();
        end
        push1(4);
        step1 = 1'b1;
        @(negedge clk);
        step1 = 1'b0;
        @(negedge clk);
        step1 = 1'b1;
        repeat (12) @(negedge clk);
        check("busy drop phase", 32'(phase1), 32'd5);
        check("busy drop idle", 32'(busy1), 32'd0);
        step1 = 1'b0;
        repeat (6) @(negedge clk);

        // Reset during M2: strobes fall asynchronously, sequence restarts at W_RW.
        rst1 = 1'b0;
        repeat (2) @(negedge clk);
        rst1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push1(k);
            press1();
        end
        q1.push_back(mk(8'h64, 4'd4));
        q1.push_back(mk(8'h70, 4'd4));
        step1 = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("M2 strobes", 32'(s1), 32'h19);
        #2;
        rst1 = 1'b0;
        #1;
        check("async reset strobes", 32'(s1), 32'h0);
        check("async reset busy", 32'(busy1), 32'h0);
        step1 = 1'b0;
        repeat (3) @(negedge clk);
        rst1 = 1'b1;
        repeat (2) @(negedge clk);
        check("post reset phase", 32'(phase1), 32'd0);
        push1(0);
        press1();
        check("post reset step phase", 32'(phase1), 32'd1);

        check("u4 queue drained", 32'(q4.size()), 32'd0);
        check("u1 queue drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
